// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock.
// A single full-subtractor cell plus a borrow flip-flop walks the operands;
// a start/busy/done handshake frames each WIDTH-cycle operation and the
// diff/borrow/overflow/zero outputs update only when a result completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_next;
    logic             bit_d;
    logic             a_msb;
    logic             b_msb;
    logic             last_bit;

    // Full-subtractor cell on the current operand LSBs and the stored borrow
    assign bit_d    = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign res_next = {bit_d, res_sr[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Control FSM, operand/result shifting and registered outputs in one process
    // NOTE: every register here uses <= so all reads see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift registers are plain flops, so clearing them costs nothing and keeps runs reproducible.
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        res_sr <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        diff     <= res_next;
                        borrow   <= br_next;
                        overflow <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
                        zero     <= (res_next == '0);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of an 8-bit instance plus an
// exhaustive sweep of a 4-bit instance against a behavioural model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] diff8;
    logic       borrow8;
    logic       ovf8;
    logic       zero8;
    logic       busy8;
    logic       done8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [3:0] diff4;
    logic       borrow4;
    logic       ovf4;
    logic       zero4;
    logic       busy4;
    logic       done4;

    int tests;
    int fails;
    int done_cnt;

    logic [10:0] prev8;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start8),
        .a        (a8),
        .b        (b8),
        .diff     (diff8),
        .borrow   (borrow8),
        .overflow (ovf8),
        .zero     (zero8),
        .busy     (busy8),
        .done     (done8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start4),
        .a        (a4),
        .b        (b4),
        .diff     (diff4),
        .borrow   (borrow4),
        .overflow (ovf4),
        .zero     (zero4),
        .busy     (busy4),
        .done     (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses of the 8-bit instance, sampled away from the active edge
    always @(negedge clk) begin
        if (done8) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation with a single-cycle start pulse
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
        int busy_len;
        int guard;
        @(negedge clk);
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~av;
        b8 = ~bv;
        chk({tag, " held"}, {21'd0, diff8, borrow8, ovf8, zero8}, {21'd0, prev8});
        busy_len = 0;
        guard = 0;
        while (busy8 && guard < 40) begin
            chk({tag, " not busy+done"}, {31'd0, busy8 & done8}, 32'd0);
            busy_len++;
            guard++;
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, busy_len, 8);
        chk({tag, " done"}, {31'd0, done8}, 32'd1);
        chk({tag, " result"}, {21'd0, diff8, borrow8, ovf8, zero8}, {21'd0, ed, eb, eo, ez});
        prev8 = {ed, eb, eo, ez};
        @(negedge clk);
        chk({tag, " done drop"}, {30'd0, done8, busy8}, 32'd0);
    endtask

    initial begin
        int d0;
        int guard;
        tests    = 0;
        fails    = 0;
        done_cnt = 0;
        prev8    = '0;
        rst_n    = 1'b0;
        start8   = 1'b0;
        a8       = '0;
        b8       = '0;
        start4   = 1'b0;
        a4       = '0;
        b4       = '0;

        #12;
        chk("reset outputs", {18'd0, diff8, borrow8, ovf8, zero8, busy8, done8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op8("sub 35-12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0);
        op8("sub 00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        op8("sub 80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        op8("sub 7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
        op8("sub 5A-5A", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1);

        // start held high; operands change right after the accepting edge
        d0 = done_cnt;
        @(negedge clk);
        a8 = 8'h10;
        b8 = 8'h03;
        start8 = 1'b1;
        @(negedge clk);
        chk("held start busy", {31'd0, busy8}, 32'd1);
        a8 = 8'hFF;
        b8 = 8'h00;
        guard = 0;
        while (busy8 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        chk("held start done1", {31'd0, done8}, 32'd1);
        chk("held start result1", {21'd0, diff8, borrow8, ovf8, zero8}, {21'd0, 8'h0D, 3'b000});
        @(negedge clk);
        chk("held start idle gap", {30'd0, busy8, done8}, 32'd0);
        @(negedge clk);
        chk("held start reaccept", {31'd0, busy8}, 32'd1);
        start8 = 1'b0;
        guard = 0;
        while (busy8 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        chk("held start done2", {31'd0, done8}, 32'd1);
        chk("held start result2", {21'd0, diff8, borrow8, ovf8, zero8}, {21'd0, 8'hFF, 3'b000});
        @(negedge clk);
        @(negedge clk);
        chk("held start done count", done_cnt - d0, 2);

        // reset during the fourth RUN cycle aborts the operation
        d0 = done_cnt;
        @(negedge clk);
        a8 = 8'h35;
        b8 = 8'h12;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy before reset", {31'd0, busy8}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort outputs cleared", {18'd0, diff8, borrow8, ovf8, zero8, busy8, done8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort no done", done_cnt - d0, 0);
        chk("abort outputs stay", {18'd0, diff8, borrow8, ovf8, zero8, busy8, done8}, 32'd0);

        // exhaustive 4-bit sweep against a signed/unsigned reference
        for (int i = 0; i < 256; i++) begin
            logic [7:0] idx;
            logic [3:0] av;
            logic [3:0] bv;
            logic [3:0] e_d;
            logic       e_b;
            logic       e_o;
            logic       e_z;
            int         sa;
            int         sb;
            int         r;
            idx = i[7:0];
            av  = idx[7:4];
            bv  = idx[3:0];
            sa  = av[3] ? int'(av) - 16 : int'(av);
            sb  = bv[3] ? int'(bv) - 16 : int'(bv);
            r   = sa - sb;
            e_d = av - bv;
            e_b = (av < bv);
            e_o = (r > 7) || (r < -8);
            e_z = (e_d == 4'd0);
            @(negedge clk);
            a4 = av;
            b4 = bv;
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            guard = 0;
            while (!done4 && guard < 20) begin
                guard++;
                @(negedge clk);
            end
            chk($sformatf("w4 %0h-%0h", av, bv), {25'd0, diff4, borrow4, ovf4, zero4},
                {25'd0, e_d, e_b, e_o, e_z});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
